// File: rtl/snn_pkg.sv
// Shared types and default sizes for the SNN frame controller.
package snn_pkg;

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StReduce, StDone} state_e;

  localparam int unsigned DefaultOutN  = 10;
  localparam int unsigned DefaultDepth = 128;
  localparam int unsigned IDX_W        = $clog2(DefaultOutN);
  localparam int unsigned ADDR_W       = $clog2(DefaultDepth);

endpackage

// File: rtl/spike_count_bank.sv
// Per-channel saturating spike counters with synchronous clear and a common enable.
module spike_count_bank #(
  parameter int unsigned OUT_N = 10,
  parameter int unsigned CNT_W = 7
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            clear,
  input  logic                            enable,
  input  logic [OUT_N-1:0]                spikes,
  output logic [OUT_N-1:0][CNT_W-1:0]     counts
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [OUT_N-1:0][CNT_W-1:0] counts_q, counts_d;

  always_comb begin
    counts_d = counts_q;
    if (clear) begin
      counts_d = '0;
    end else if (enable) begin
      for (int k = 0; k < int'(OUT_N); k++) begin
        // Saturate by refusing the increment once all-ones is reached.
        if (spikes[k] && (counts_q[k] != CntMax)) begin
          counts_d[k] = counts_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      counts_q <= '0;
    end else begin
      counts_q <= counts_d;
    end
  end

  assign counts = counts_q;

endmodule

// File: rtl/snn_frame_controller.sv
// Buffers one input frame, replays it REPEAT times into a spiking network, counts output
// spikes per channel and reports the argmax class over a valid/ready result port.
module snn_frame_controller
  import snn_pkg::*;
#(
  parameter int unsigned IN_W    = 19,
  parameter int unsigned DEPTH   = DefaultDepth,
  parameter int unsigned OUT_N   = DefaultOutN,
  parameter int unsigned CNT_W   = 7,
  parameter int unsigned REPEAT  = 1,
  parameter int unsigned NET_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [IN_W-1:0]            in_data_i,
  input  logic                       in_last_i,
  input  logic                       abort_i,
  output logic                       net_valid_o,
  output logic [IN_W-1:0]            net_data_o,
  input  logic [OUT_N-1:0]           spike_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [$clog2(OUT_N)-1:0]   result_idx_o,
  output logic [CNT_W-1:0]           result_cnt_o
);

  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned IdxW   = $clog2(OUT_N);
  localparam int unsigned PassW  = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int          ChainW = int'(NET_LAT) + 1;

  localparam logic [AddrW-1:0]  LastPtr  = AddrW'(DEPTH - 1);
  localparam logic [PassW-1:0]  LastPass = PassW'(REPEAT - 1);
  localparam logic [IdxW-1:0]   LastCh   = IdxW'(OUT_N - 1);
  // Only the final live step is left in the latency pipe, at its counting stage.
  localparam logic [ChainW-1:0] LastBeat = ChainW'(1) << NET_LAT;

  state_e                      state_q, state_d;
  logic [AddrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]            rd_addr_q, rd_addr_d;
  logic [AddrW-1:0]            last_addr_q, last_addr_d;
  logic [PassW-1:0]            pass_q, pass_d;
  logic [ChainW-1:0]           chain_q, chain_d;
  logic [IdxW-1:0]             red_idx_q, red_idx_d;
  logic [IdxW-1:0]             best_idx_q, best_idx_d;
  logic [CNT_W-1:0]            best_cnt_q, best_cnt_d;
  logic [IN_W-1:0]             mem [DEPTH];
  logic [IN_W-1:0]             rd_data_q;
  logic [OUT_N-1:0][CNT_W-1:0] counts;
  logic                        accept, frame_end;

  assign accept    = in_valid_i && (state_q == StIdle) && !abort_i;
  assign frame_end = accept && (in_last_i || (wr_ptr_q == LastPtr));

  spike_count_bank #(
    .OUT_N (OUT_N),
    .CNT_W (CNT_W)
  ) u_count_bank (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (abort_i || frame_end),
    .enable (chain_q[NET_LAT]),
    .spikes (spike_i),
    .counts (counts)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_addr_d   = rd_addr_q;
    last_addr_d = last_addr_q;
    pass_d      = pass_q;
    red_idx_d   = red_idx_q;
    best_idx_d  = best_idx_q;
    best_cnt_d  = best_cnt_q;
    chain_d     = '0;
    chain_d[0]  = (state_q == StRun);
    for (int i = 1; i < ChainW; i++) begin
      chain_d[i] = chain_q[i-1];
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + AddrW'(1);
          if (frame_end) begin
            last_addr_d = wr_ptr_q;
            wr_ptr_d    = '0;
            rd_addr_d   = '0;
            pass_d      = '0;
            state_d     = StRun;
          end
        end
      end
      StRun: begin
        if (rd_addr_q == last_addr_q) begin
          rd_addr_d = '0;
          if (pass_q == LastPass) begin
            state_d = StDrain;
          end else begin
            pass_d = pass_q + PassW'(1);
          end
        end else begin
          rd_addr_d = rd_addr_q + AddrW'(1);
        end
      end
      StDrain: begin
        if (chain_q == LastBeat) begin
          red_idx_d  = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          state_d    = StReduce;
        end
      end
      StReduce: begin
        // Strictly-greater replacement keeps the lowest index on ties.
        if (counts[red_idx_q] > best_cnt_q) begin
          best_idx_d = red_idx_q;
          best_cnt_d = counts[red_idx_q];
        end
        red_idx_d = red_idx_q + IdxW'(1);
        if (red_idx_q == LastCh) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (result_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort_i) begin
      state_d    = StIdle;
      wr_ptr_d   = '0;
      rd_addr_d  = '0;
      pass_d     = '0;
      chain_d    = '0;
      red_idx_d  = '0;
      best_idx_d = '0;
      best_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_addr_q   <= '0;
      last_addr_q <= '0;
      pass_q      <= '0;
      chain_q     <= '0;
      red_idx_q   <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_addr_q   <= rd_addr_d;
      last_addr_q <= last_addr_d;
      pass_q      <= pass_d;
      chain_q     <= chain_d;
      red_idx_q   <= red_idx_d;
      best_idx_q  <= best_idx_d;
      best_cnt_q  <= best_cnt_d;
    end
  end

  // Single-port frame buffer: written only in IDLE, read only in RUN.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q] <= in_data_i;
    end else if (state_q == StRun) begin
      rd_data_q <= mem[rd_addr_q];
    end
  end

  assign in_ready_o     = (state_q == StIdle);
  assign net_valid_o    = chain_q[0];
  assign net_data_o     = chain_q[0] ? rd_data_q : '0;
  assign result_valid_o = (state_q == StDone);
  assign result_idx_o   = best_idx_q;
  assign result_cnt_o   = best_cnt_q;

endmodule

// File: tb/tb_snn_frame_controller.sv
// Bench for snn_frame_controller: three parameterisations driven one at a time, each fed by a
// fake network that echoes data bits [9:0] as spikes after NET_LAT cycles.
module tb_snn_frame_controller;

  localparam int REP  [3] = '{1, 4, 1};
  localparam int NLAT [3] = '{1, 2, 0};
  localparam int CMAX [3] = '{127, 127, 7};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, in_valid, in_last, abort, result_ready;
  logic [18:0] in_data;
  int          sel;

  logic rdy_a, rdy_b, rdy_c, nv_a, nv_b, nv_c, rv_a, rv_b, rv_c;
  logic [18:0] nd_a, nd_b, nd_c;
  logic [9:0]  spike_a, spike_b, spike_c;
  logic [3:0]  idx_a, idx_b, idx_c;
  logic [6:0]  cnt_a, cnt_b;
  logic [2:0]  cnt_c;

  logic        cur_ready, cur_nv, cur_rv;
  logic [18:0] cur_nd;
  logic [3:0]  cur_idx;
  logic [6:0]  cur_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [18:0] fw[$];

  snn_frame_controller #(.IN_W(19), .DEPTH(128), .OUT_N(10), .CNT_W(7), .REPEAT(1),
                         .NET_LAT(1)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid_i(in_valid && sel == 0), .in_ready_o(rdy_a),
    .in_data_i(in_data), .in_last_i(in_last), .abort_i(abort && sel == 0),
    .net_valid_o(nv_a), .net_data_o(nd_a), .spike_i(spike_a), .result_valid_o(rv_a),
    .result_ready_i(result_ready), .result_idx_o(idx_a), .result_cnt_o(cnt_a));

  snn_frame_controller #(.IN_W(19), .DEPTH(16), .OUT_N(10), .CNT_W(7), .REPEAT(4),
                         .NET_LAT(2)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid_i(in_valid && sel == 1), .in_ready_o(rdy_b),
    .in_data_i(in_data), .in_last_i(in_last), .abort_i(abort && sel == 1),
    .net_valid_o(nv_b), .net_data_o(nd_b), .spike_i(spike_b), .result_valid_o(rv_b),
    .result_ready_i(result_ready), .result_idx_o(idx_b), .result_cnt_o(cnt_b));

  snn_frame_controller #(.IN_W(19), .DEPTH(16), .OUT_N(10), .CNT_W(3), .REPEAT(1),
                         .NET_LAT(0)) dut_c (
    .clk(clk), .rstn(rstn), .in_valid_i(in_valid && sel == 2), .in_ready_o(rdy_c),
    .in_data_i(in_data), .in_last_i(in_last), .abort_i(abort && sel == 2),
    .net_valid_o(nv_c), .net_data_o(nd_c), .spike_i(spike_c), .result_valid_o(rv_c),
    .result_ready_i(result_ready), .result_idx_o(idx_c), .result_cnt_o(cnt_c));

  // Fake networks: random spikes whenever no live step is due, so stray counting shows up.
  logic [9:0] noise = '0;
  logic       a_v = 1'b0;
  logic [9:0] a_d = '0;
  logic [1:0] b_v = '0;
  logic [9:0] b_d0 = '0, b_d1 = '0;
  always @(posedge clk) begin
    noise <= 10'($urandom);
    a_v   <= nv_a;
    a_d   <= nd_a[9:0];
    b_v   <= {b_v[0], nv_b};
    b_d0  <= nd_b[9:0];
    b_d1  <= b_d0;
  end
  assign spike_a = a_v ? a_d : noise;
  assign spike_b = b_v[1] ? b_d1 : noise;
  assign spike_c = nv_c ? nd_c[9:0] : noise;

  always_comb begin
    cur_ready = rdy_a; cur_nv = nv_a; cur_nd = nd_a; cur_rv = rv_a;
    cur_idx = idx_a; cur_cnt = cnt_a;
    case (sel)
      1: begin
        cur_ready = rdy_b; cur_nv = nv_b; cur_nd = nd_b; cur_rv = rv_b;
        cur_idx = idx_b; cur_cnt = cnt_b;
      end
      2: begin
        cur_ready = rdy_c; cur_nv = nv_c; cur_nd = nd_c; cur_rv = rv_c;
        cur_idx = idx_c; cur_cnt = {4'b0, cnt_c};
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s (sel %0d): got %0d, expected %0d", name, sel, got, exp);
    end
  endtask

  // Reference: per-channel spike totals over the replayed frame, saturated, strict argmax.
  function automatic void model(input int s, input int len, output int e_idx, output int e_cnt);
    int c;
    e_idx = 0;
    e_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      c = 0;
      for (int w = 0; w < len; w++) c += int'(fw[w][k]);
      c *= REP[s];
      if (c > CMAX[s]) c = CMAX[s];
      if (c > e_cnt) begin
        e_cnt = c;
        e_idx = k;
      end
    end
  endfunction

  task automatic send_words(input int len, input bit use_last, input bit gaps);
    int acc = 0;
    int guard = 0;
    logic rdy;
    while (acc < len && guard < 1000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = fw[acc];
        in_last  = use_last && (acc == len - 1);
      end
      rdy = cur_ready;
      @(posedge clk);
      if (in_valid && rdy) acc++;
    end
    if (acc < len) check("send_accept_count", acc, len);
  endtask

  // Called right after the last-accept edge; cycle 1 is the first cycle after it.
  task automatic wait_result(input int s, input int len, input int extra, input int rdy_dly,
                             output int g_idx, output int g_cnt);
    int cyc = 0, rv_at = -1, nv = 0, derr = 0, unst = 0;
    bit hs = 1'b0;
    g_idx = -1;
    g_cnt = -1;
    result_ready = (rdy_dly < 0);
    while (!hs && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      in_last = 1'b0;
      if (cyc <= extra) begin
        in_valid = 1'b1;
        in_data  = fw[len + cyc - 1];
      end else begin
        in_valid = 1'b0;
      end
      if (cyc == 1) check("ready_low_after_frame", int'(cur_ready), 0);
      if (cur_nv) begin
        if (cur_nd !== fw[nv % len]) derr++;
        nv++;
      end else if (cur_nd !== '0) begin
        derr++;
      end
      if (cur_rv) begin
        if (rv_at < 0) begin
          rv_at = cyc;
          g_idx = int'(cur_idx);
          g_cnt = int'(cur_cnt);
        end else if (int'(cur_idx) != g_idx || int'(cur_cnt) != g_cnt) begin
          unst++;
        end
        if (rdy_dly < 0 || cyc - rv_at >= rdy_dly) result_ready = 1'b1;
        if (result_ready) hs = 1'b1;
      end
    end
    if (!hs) begin
      check("result_timeout", 0, 1);
    end else begin
      @(negedge clk);
      result_ready = 1'b0;
      check("result_valid_drops", int'(cur_rv), 0);
      check("idle_after_result", int'(cur_ready), 1);
    end
    check("latency", rv_at, len * REP[s] + NLAT[s] + 12);
    check("live_steps", nv, len * REP[s]);
    check("replay_data_errors", derr, 0);
    check("result_stable", unst, 0);
  endtask

  typedef struct {
    int          sel;
    int          len;
    int          split;
    logic [18:0] wa;
    logic [18:0] wb;
    int          rdy;
    int          eidx;
    int          ecnt;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int gi, gc, ei, ec, s, len, rvs;

    tbl[0] = '{0, 3, 3, 19'h00004, 19'h00000, 0, 2, 3};
    tbl[1] = '{1, 5, 5, 19'h00080, 19'h00000, 2, 7, 20};
    tbl[2] = '{2, 12, 6, 19'h00012, 19'h00002, -1, 1, 7};
    tbl[3] = '{0, 5, 5, 19'h00048, 19'h00000, 1, 3, 5};
    tbl[4] = '{0, 4, 4, 19'h00000, 19'h00000, 0, 0, 0};
    tbl[5] = '{1, 3, 1, 19'h00201, 19'h00200, -1, 9, 12};
    tbl[6] = '{2, 1, 1, 19'h003FF, 19'h00000, 0, 0, 1};
    tbl[7] = '{0, 8, 3, 19'h400C0, 19'h20100, 3, 8, 5};

    rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0; abort = 1'b0; result_ready = 1'b0;
    in_data = '0; sel = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check("reset_in_ready", int'(cur_ready), 1);
      check("reset_net_valid", int'(cur_nv), 0);
      check("reset_net_data", int'(cur_nd), 0);
      check("reset_result_valid", int'(cur_rv), 0);
      check("reset_result_idx", int'(cur_idx), 0);
      check("reset_result_cnt", int'(cur_cnt), 0);
    end
    @(negedge clk);
    rstn = 1'b1;

    // Directed table.
    for (int t = 0; t < 8; t++) begin
      sel = tbl[t].sel;
      fw.delete();
      for (int w = 0; w < tbl[t].len; w++) fw.push_back(w < tbl[t].split ? tbl[t].wa : tbl[t].wb);
      send_words(tbl[t].len, 1'b1, 1'b0);
      wait_result(tbl[t].sel, tbl[t].len, 0, tbl[t].rdy, gi, gc);
      check($sformatf("tbl%0d_idx", t), gi, tbl[t].eidx);
      check($sformatf("tbl%0d_cnt", t), gc, tbl[t].ecnt);
    end

    // Overflow: 130 words offered without last, only 128 taken.
    sel = 0;
    fw.delete();
    for (int w = 0; w < 130; w++) fw.push_back(w < 60 ? 19'h00004 : 19'h00008);
    send_words(128, 1'b0, 1'b0);
    wait_result(0, 128, 2, 0, gi, gc);
    check("overflow_idx", gi, 3);
    check("overflow_cnt", gc, 68);

    // Abort mid-RUN with result_ready high.
    fw.delete();
    for (int w = 0; w < 20; w++) fw.push_back(19'h00100);
    send_words(20, 1'b1, 1'b0);
    repeat (8) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    abort = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_net_valid", int'(cur_nv), 0);
    check("abort_to_idle", int'(cur_ready), 1);
    rvs = 0;
    repeat (40) begin
      @(negedge clk);
      if (cur_rv) rvs++;
    end
    check("abort_no_result", rvs, 0);
    result_ready = 1'b0;

    // Abort beats a simultaneous last word.
    in_valid = 1'b1; in_last = 1'b1; in_data = 19'h00001; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("abort_wins_over_input", int'(cur_ready), 1);
    fw.delete();
    fw.push_back(19'h00001);
    fw.push_back(19'h00001);
    send_words(2, 1'b1, 1'b0);
    wait_result(0, 2, 0, 0, gi, gc);
    check("post_abort_idx", gi, 0);
    check("post_abort_cnt", gc, 2);

    // Randomised frames against the model.
    for (int r = 0; r < 14; r++) begin
      s = $urandom_range(0, 2);
      sel = s;
      len = $urandom_range(1, s == 0 ? 24 : 16);
      fw.delete();
      for (int w = 0; w < len; w++) fw.push_back(19'($urandom));
      model(s, len, ei, ec);
      send_words(len, 1'b1, 1'($urandom_range(0, 1)));
      wait_result(s, len, 0, int'($urandom_range(0, 4)) - 1, gi, gc);
      check($sformatf("rand%0d_idx", r), gi, ei);
      check($sformatf("rand%0d_cnt", r), gc, ec);
    end

    // Reset while a result is pending clears the result port.
    sel = 1;
    fw.delete();
    for (int w = 0; w < 4; w++) fw.push_back(19'h00020);
    send_words(4, 1'b1, 1'b0);
    begin
      int guard = 0;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      while (!cur_rv && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      check("pre_reset_result_cnt", int'(cur_cnt), 16);
    end
    rstn = 1'b0;
    #1;
    check("midrun_reset_result_valid", int'(cur_rv), 0);
    check("midrun_reset_result_idx", int'(cur_idx), 0);
    check("midrun_reset_result_cnt", int'(cur_cnt), 0);
    check("midrun_reset_in_ready", int'(cur_ready), 1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
